// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_fulladd4.sv
// fulladd4: 4-bit ripple-carry adder slice, the only arithmetic in the serial adder.
module fulladd4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = c_in;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    c_out = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder: one nibble per clock through fulladd4, valid/ready on both sides.
// Optional signed-overflow output when NIBBLE_SERIAL_ADDER_OVF_EN is defined.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter  int WIDTH   = 16,
  localparam int NIBBLES = WIDTH / NIBBLE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             c_out
);

  // Handshake: a transfer happens on an edge where valid && ready are both high.
  // in_ready is high only in IDLE, out_valid only in DONE; both come straight from state.

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]   sum_q;
  logic               c_out_q;
  logic [NIBBLE_W-1:0] nib_sum;
  logic               nib_c;
  logic               last;

  fulladd4 u_slice (
    .a     (a_q[NIBBLE_W-1:0]),
    .b     (b_q[NIBBLE_W-1:0]),
    .c_in  (carry),
    .sum   (nib_sum),
    .c_out (nib_c)
  );

  // New nibble enters at the top so the LSB nibble ends up at the bottom after NIBBLES shifts.
  assign acc_nxt = (acc >> NIBBLE_W) | (WIDTH'(nib_sum) << (WIDTH - NIBBLE_W));
  assign last    = (cnt == CNT_W'(NIBBLES - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = ADD;
      ADD:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      carry   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= c_in;
            cnt   <= '0;
          end
        end
        ADD: begin
          a_q   <= a_q >> NIBBLE_W;
          b_q   <= b_q >> NIBBLE_W;
          acc   <= acc_nxt;
          carry <= nib_c;
          cnt   <= cnt + CNT_W'(1);
          // Result registers only change here, so they hold through DONE and beyond.
          if (last) begin
            sum_q   <= acc_nxt;
            c_out_q <= nib_c;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic a_msb_q;
  logic b_msb_q;
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        a_msb_q <= a[WIDTH-1];
        b_msb_q <= b[WIDTH-1];
      end
      if (state == ADD && last)
        ovf_q <= (a_msb_q == b_msb_q) && (acc_nxt[WIDTH-1] != a_msb_q);
    end
  end

  assign ovf = ovf_q;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16), with or without NIBBLE_SERIAL_ADDER_OVF_EN.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int W     = WIDTH + 2;  // {ovf, c_out, sum}

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             c_in = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .c_out     (c_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "bench timed out");
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic ci);
    @(negedge clk);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = av; b = bv; c_in = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble operands after accept; they must not affect the result.
    a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      chk("in_ready_low_during_add", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    if (out_valid !== 1'b1) chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_drops_after_consume", 32'(out_valid), 32'd0);
    chk("in_ready_back_after_consume", 32'(in_ready), 32'd1);
  endtask

  function automatic logic [W-1:0] model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                         input logic ci);
    logic [WIDTH:0] full;
    logic           ov;
    full = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, ci};
    ov   = (av[WIDTH-1] == bv[WIDTH-1]) && (full[WIDTH-1] != av[WIDTH-1]);
    return {ov, full};
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    int n_res;
    logic [W-1:0] e;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[6] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h8001, 16'h8001, 1'b0, 16'h0002, 1'b1, 1'b1};

    // Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_c_out", 32'(c_out), 32'd0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    chk("reset_ovf", 32'(ovf), 32'd0);
`endif

    // Table-driven vectors
    foreach (vecs[i]) begin
      apply_op(vecs[i].a, vecs[i].b, vecs[i].ci);
      wait_result(lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].s));
      chk($sformatf("vec%0d_c_out", i), 32'(c_out), 32'(vecs[i].co));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ov));
`endif
      consume();
    end

    // Backpressure: result holds while out_ready is low; new in_valid ignored
    apply_op(16'h00FF, 16'h0001, 1'b0);
    wait_result(lat);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'h5555; b = 16'h1111; c_in = 1'b1;
      @(posedge clk); #1;
      chk("bp_sum_stable", 32'(sum), 32'h0100);
      chk("bp_c_out_stable", 32'(c_out), 32'd0);
      chk("bp_out_valid_held", 32'(out_valid), 32'd1);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    consume();
    @(posedge clk); #1;
    chk("bp_no_ghost_accept", 32'(in_ready), 32'd1);
    chk("bp_sum_after_idle", 32'(sum), 32'h0100);

    // Reset on the 2nd ADD edge discards the operation
    apply_op(16'h1234, 16'h1111, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_c_out", 32'(c_out), 32'd0);
    begin
      logic seen;
      seen = 1'b0;
      repeat (6) begin
        @(posedge clk); #1;
        if (out_valid === 1'b1) seen = 1'b1;
      end
      chk("midrst_no_result", 32'(seen), 32'd0);
    end

    // Reset and in_valid together: nothing is accepted
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; a = 16'h0005; b = 16'h0005;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_wins_in_ready", 32'(in_ready), 32'd1);

    apply_op(16'h0001, 16'h0001, 1'b0);
    wait_result(lat);
    chk("post_rst_latency", 32'(lat), 32'd4);
    chk("post_rst_sum", 32'(sum), 32'h0002);
    consume();

    // Random stream with scoreboard
    n_res = 0;
    for (int k = 0; k < 20; k++) begin
      logic [WIDTH-1:0] ra, rb;
      logic             rc;
      int               stall;
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom_range(0, 1));
      exp_q.push_back(model(ra, rb, rc));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      apply_op(ra, rb, rc);
      wait_result(lat);
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        chk("rnd_stall_valid", 32'(out_valid), 32'd1);
      end
      if (exp_q.size() == 0) begin
        chk("rnd_unexpected_result", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("rnd%0d_sum", k), 32'(sum), 32'(e[WIDTH-1:0]));
        chk($sformatf("rnd%0d_c_out", k), 32'(c_out), 32'(e[WIDTH]));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        chk($sformatf("rnd%0d_ovf", k), 32'(ovf), 32'(e[WIDTH+1]));
`endif
        n_res++;
      end
      consume();
    end
    chk("rnd_result_count", 32'(n_res), 32'd20);
    chk("rnd_queue_empty", 32'(exp_q.size()), 32'd0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
